iir_mac_sequencer: RTL and testbench

- Parametrised successor to the fixed 7-state biquad sequencer.
- Drives the shared multiplier/accumulator datapath for a direct-form-I IIR with NB feedforward and NA feedback taps.
- Time-multiplexes NCH channels per input frame and absorbs a configurable multiplier pipeline latency.
- Adds a valid/ready frame handshake and per-channel output-valid strobes.
- Sits between the sample front-end and the filter datapath (coefficient ROM, x/y history memories, MAC, output register).

---
 rtl/iir_seq_pkg.sv | 8 +
 rtl/iir_seq_delay.sv | 19 +
 rtl/iir_mac_sequencer.sv | 140 ++++++++++++++
 tb/tb_iir_mac_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/iir_seq_pkg.sv
// iir_seq_pkg: state encoding and timing helper shared by the IIR MAC sequencer
package iir_seq_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {IDLE, LOAD, MAC, DRAIN, WRITE} state_t;
  function automatic int cycles_per_ch(input int nb, input int na, input int lat);
    return nb + na + lat + 2;
  endfunction
endpackage

// File: rtl/iir_seq_delay.sv
// iir_seq_delay: LAT-deep enable-gated 1-bit shift register aligning acc_enable with the multiplier output
// Ports: clk, reset_n (async active-low), en (shift step), d (mult_enable), q (d delayed LAT enabled cycles)
module iir_seq_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);
  logic [LAT-1:0] sr;
  logic [LAT:0] nxt;
  assign nxt = {sr, d};
  assign q = nxt[LAT];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else if (en) sr <= nxt[LAT-1:0];
endmodule

// File: rtl/iir_mac_sequencer.sv
// iir_mac_sequencer: multi-channel direct-form-I IIR MAC sequencer with frame handshake
// Ports: clk, reset_n (async active-low), enable (global step), in_valid/in_ready (frame handshake),
//   mult_reset/mult_enable, acc_reset/acc_enable, x_mem_enable/y_mem_enable, output_reg_enable,
//   mem_sel/mem_dir (history operand), coef_addr, ch_sel, out_valid, overrun.
// Optional: define IIR_SEQ_OVERRUN_EN for a sticky flag on frames offered while busy.
module iir_mac_sequencer
  import iir_seq_pkg::*;
#(
  parameter int NB       = 3,
  parameter int NA       = 2,
  parameter int NCH      = 1,
  parameter int MULT_LAT = 1,
  parameter int TAP_W    = 4,
  parameter int CH_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mult_reset,
  output logic             mult_enable,
  output logic             acc_reset,
  output logic             acc_enable,
  output logic             x_mem_enable,
  output logic             y_mem_enable,
  output logic             output_reg_enable,
  output logic             mem_sel,
  output logic [TAP_W-1:0] mem_dir,
  output logic [TAP_W-1:0] coef_addr,
  output logic [CH_W-1:0]  ch_sel,
  output logic             out_valid,
  output logic             overrun
);
  state_t state, state_d;
  logic [TAP_W-1:0] tap, tap_d;
  logic [CH_W-1:0] ch, ch_d;
  logic [2:0] dcnt, dcnt_d;
  logic tap_last, dly_last, ch_last;
  assign tap_last  = tap == TAP_W'(NB + NA - 1);
  assign dly_last  = dcnt == 3'(MULT_LAT - 1);
  assign ch_last   = ch == CH_W'(NCH - 1);
  assign coef_addr = tap;
  assign mem_sel   = tap >= TAP_W'(NB);
  assign mem_dir   = mem_sel ? tap - TAP_W'(NB) : tap;
  assign ch_sel    = ch;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      tap   <= '0;
      ch    <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      tap   <= tap_d;
      ch    <= ch_d;
      dcnt  <= dcnt_d;
    end
  always_comb begin
    state_d = state;
    tap_d = tap;
    ch_d = ch;
    dcnt_d = dcnt;
    in_ready = 1'b0;
    mult_reset = 1'b0;
    mult_enable = 1'b0;
    acc_reset = 1'b0;
    x_mem_enable = 1'b0;
    y_mem_enable = 1'b0;
    output_reg_enable = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset_n;
        if (in_valid) begin
          state_d = LOAD;
          ch_d = '0;
        end
      end
      LOAD: begin
        acc_reset = 1'b1;
        x_mem_enable = 1'b1;
        mult_reset = 1'b1;
        tap_d = '0;
        state_d = MAC;
      end
      MAC: begin
        mult_enable = 1'b1;
        tap_d = tap_last ? '0 : tap + 1'b1;
        state_d = !tap_last ? MAC : MULT_LAT == 0 ? WRITE : DRAIN;
      end
      DRAIN: begin
        mult_reset = 1'b1;
        dcnt_d = dly_last ? '0 : dcnt + 1'b1;
        state_d = dly_last ? WRITE : DRAIN;
      end
      WRITE: begin
        output_reg_enable = 1'b1;
        y_mem_enable = 1'b1;
        out_valid = 1'b1;
        ch_d = ch_last ? ch : ch + 1'b1;
        state_d = ch_last ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = state;
      tap_d = tap;
      ch_d = ch;
      dcnt_d = dcnt;
      in_ready = 1'b0;
      mult_reset = 1'b0;
      mult_enable = 1'b0;
      acc_reset = 1'b0;
      x_mem_enable = 1'b0;
      y_mem_enable = 1'b0;
      output_reg_enable = 1'b0;
      out_valid = 1'b0;
    end
  end
  // acc_enable trails mult_enable by the multiplier depth, counted in enabled cycles only
  generate
    if (MULT_LAT == 0) begin : g_comb
      assign acc_enable = mult_enable;
    end else begin : g_dly
      logic q;
      iir_seq_delay #(.LAT(MULT_LAT)) u_dly (
        .clk(clk), .reset_n(reset_n), .en(enable), .d(mult_enable), .q(q)
      );
      assign acc_enable = enable & q;
    end
  endgenerate
`ifdef IIR_SEQ_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overrun <= 1'b0;
    else if (in_valid && enable && !in_ready) overrun <= 1'b1;
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_iir_mac_sequencer.sv
// tb_iir_mac_sequencer: three configurations checked against a frame-position model plus literal timelines
module tb_iir_mac_sequencer;
  localparam int RDY = 0, MR = 1, ME = 2, AR = 3, AE = 4, XM = 5, YM = 6, ORE = 7, OV = 8, OVR = 9;
  typedef struct packed {
    logic [9:0] s;
    logic       sel;
    logic [3:0] dir;
    logic [3:0] coef;
    logic [3:0] ch;
  } outs_t;
  logic clk = 0, rstn = 0, enable = 0, in_valid = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0;
  logic [2:0] in_ready, mult_reset, mult_enable, acc_reset, acc_enable, x_mem_enable, y_mem_enable;
  logic [2:0] output_reg_enable, mem_sel, out_valid, overrun;
  logic [3:0] mem_dir [3], coef_addr [3], ch_sel [3];
  function automatic int pnb(int i);  return i == 0 ? 3 : i == 1 ? 2 : 1; endfunction
  function automatic int pna(int i);  return i == 0 ? 2 : i == 1 ? 1 : 0; endfunction
  function automatic int pnch(int i); return i == 1 ? 3 : 1; endfunction
  function automatic int pml(int i);  return i == 0 ? 1 : i == 1 ? 2 : 0; endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    iir_mac_sequencer #(
      .NB(g == 0 ? 3 : g == 1 ? 2 : 1), .NA(g == 0 ? 2 : g == 1 ? 1 : 0),
      .NCH(g == 1 ? 3 : 1), .MULT_LAT(g == 0 ? 1 : g == 1 ? 2 : 0), .TAP_W(4), .CH_W(4)
    ) u (
      .clk(clk), .reset_n(rstn), .enable(enable), .in_valid(in_valid), .in_ready(in_ready[g]),
      .mult_reset(mult_reset[g]), .mult_enable(mult_enable[g]), .acc_reset(acc_reset[g]),
      .acc_enable(acc_enable[g]), .x_mem_enable(x_mem_enable[g]), .y_mem_enable(y_mem_enable[g]),
      .output_reg_enable(output_reg_enable[g]), .mem_sel(mem_sel[g]), .mem_dir(mem_dir[g]),
      .coef_addr(coef_addr[g]), .ch_sel(ch_sel[g]), .out_valid(out_valid[g]), .overrun(overrun[g])
    );
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  // Model: a busy channel frame is a position k counted in enabled cycles since accept
  bit busy [3];
  int k [3];
  bit ovr [3];
  always @(posedge clk or negedge rstn)
    for (int i = 0; i < 3; i++)
      if (!rstn) begin
        busy[i] <= 0;
        k[i] <= 0;
        ovr[i] <= 0;
      end else if (enable) begin
        if (in_valid && busy[i]) ovr[i] <= 1;
        if (!busy[i]) begin
          if (in_valid) begin
            busy[i] <= 1;
            k[i] <= 0;
          end
        end else if (k[i] == pnch(i) * (pnb(i) + pna(i) + pml(i) + 2) - 1) busy[i] <= 0;
        else k[i] <= k[i] + 1;
      end
  function automatic outs_t model(int i, bit b, int kk, bit en, bit rn);
    outs_t o;
    int nt, p, j, tp;
    o = '0;
    if (!rn || !en) return o;
    if (!b) begin
      o.s[RDY] = 1;
      return o;
    end
    nt = pnb(i) + pna(i);
    p = nt + pml(i) + 2;
    j = kk % p;
    tp = j - 1;
    o.ch = 4'(kk / p);
    o.s[AR] = j == 0;
    o.s[XM] = j == 0;
    o.s[MR] = j == 0 || (j > nt && j < p - 1);
    o.s[ME] = j >= 1 && j <= nt;
    o.s[AE] = j > pml(i) && j <= pml(i) + nt;
    o.s[ORE] = j == p - 1;
    o.s[YM] = j == p - 1;
    o.s[OV] = j == p - 1;
    if (o.s[ME]) begin
      o.coef = 4'(tp);
      o.sel = tp >= pnb(i);
      o.dir = 4'(o.sel ? tp - pnb(i) : tp);
    end
    return o;
  endfunction
  function automatic outs_t act(int i);
    outs_t o;
    o.s = {overrun[i], out_valid[i], output_reg_enable[i], y_mem_enable[i], x_mem_enable[i],
           acc_enable[i], acc_reset[i], mult_enable[i], mult_reset[i], in_ready[i]};
    o.sel = mem_sel[i];
    o.dir = mem_dir[i];
    o.coef = coef_addr[i];
    o.ch = ch_sel[i];
    return o;
  endfunction
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      outs_t e, a;
      e = model(i, busy[i], k[i], enable, rstn);
`ifdef IIR_SEQ_OVERRUN_EN
      e.s[OVR] = ovr[i];
`endif
      a = act(i);
      chk($sformatf("d%0d_strobes", i), int'(a.s), int'(e.s));
      if (e.s[ME]) chk($sformatf("d%0d_index", i), int'({a.sel, a.dir, a.coef}), int'({e.sel, e.dir, e.coef}));
      if (busy[i] && rstn) chk($sformatf("d%0d_ch", i), int'(a.ch), int'(e.ch));
    end
  int xm1 = 0, ym1 = 0, me0 = 0, ae0 = 0, ov0 = 0, acc0 = 0;
  int ov1_t [$];
  int ov1_ch [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid[1]) begin
      ov1_t.push_back(cyc);
      ov1_ch.push_back(int'(ch_sel[1]));
    end
    xm1 += int'(x_mem_enable[1]);
    ym1 += int'(y_mem_enable[1]);
    me0 += int'(mult_enable[0]);
    ae0 += int'(acc_enable[0]);
    ov0 += int'(out_valid[0]);
    if (in_valid && in_ready[0]) acc0++;
  end
  task automatic start_frame();
    @(posedge clk);
    #1 in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  // Literal timeline for the default and 3-cycle configurations, cycle 0 = accept
  task automatic frame_lit();
    for (int t = 1; t <= 9; t++) begin
      outs_t m;
      @(negedge clk);
      m = model(0, busy[0], k[0], enable, rstn);
      chk("d0_acc_reset", int'(acc_reset[0]), int'(t == 1));
      chk("d0_mult_enable", int'(mult_enable[0]), int'(t >= 2 && t <= 6));
      chk("d0_acc_enable", int'(acc_enable[0]), int'(t >= 3 && t <= 7));
      chk("d0_out_valid", int'(out_valid[0]), int'(t == 8));
      chk("d0_in_ready", int'(in_ready[0]), int'(t == 9));
      if (t >= 2 && t <= 6) begin
        chk("d0_coef", int'(coef_addr[0]), t - 2);
        chk("d0_mem_sel", int'(mem_sel[0]), int'(t >= 5));
        chk("d0_mem_dir", int'(mem_dir[0]), t < 5 ? t - 2 : t - 5);
        chk("model_coef", int'(m.coef), t - 2);
        chk("model_mem_dir", int'(m.dir), t < 5 ? t - 2 : t - 5);
      end
      chk("model_acc_enable", int'(m.s[AE]), int'(t >= 3 && t <= 7));
      chk("d2_mult_enable", int'(mult_enable[2]), int'(t == 2));
      chk("d2_acc_enable", int'(acc_enable[2]), int'(t == 2));
      chk("d2_out_valid", int'(out_valid[2]), int'(t == 3));
      chk("d2_in_ready", int'(in_ready[2]), int'(t >= 4));
    end
  endtask
  initial begin
    int b_me, b_ae, b_ov, b_xm, b_ym, b_acc;
    enable = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_strobes", int'({mult_reset, mult_enable, acc_reset, acc_enable, out_valid}), 0);
    chk("reset_coef", int'(coef_addr[0]), 0);
    #1 rstn = 1;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 7);
    start_frame();
    frame_lit();
    repeat (15) @(posedge clk);
    chk("d1_out_valid_count", ov1_t.size(), 3);
    chk("d1_spacing_a", ov1_t[1] - ov1_t[0], 7);
    chk("d1_spacing_b", ov1_t[2] - ov1_t[1], 7);
    chk("d1_ch_0", ov1_ch[0], 0);
    chk("d1_ch_1", ov1_ch[1], 1);
    chk("d1_ch_2", ov1_ch[2], 2);
    chk("d1_x_mem_count", xm1, 3);
    chk("d1_y_mem_count", ym1, 3);
    b_me = me0; b_ae = ae0; b_ov = ov0; b_xm = xm1; b_ym = ym1;
    start_frame();
    repeat (3) @(posedge clk);
    #1 enable = 0;
    @(negedge clk);
    chk("stall_coef", int'(coef_addr[0]), 2);
    chk("stall_strobes", int'({mult_enable, acc_enable, mult_reset, in_ready}), 0);
    repeat (3) @(posedge clk);
    #1 enable = 1;
    @(negedge clk);
    chk("resume_coef", int'(coef_addr[0]), 2);
    chk("resume_mult_enable", int'(mult_enable[0]), 1);
    repeat (25) @(posedge clk);
    chk("stall_me_count", me0 - b_me, 5);
    chk("stall_ae_count", ae0 - b_ae, 5);
    chk("stall_ov_count", ov0 - b_ov, 1);
    chk("stall_d1_x_count", xm1 - b_xm, 3);
    chk("stall_d1_y_count", ym1 - b_ym, 3);
    start_frame();
    repeat (6) @(posedge clk);
    #1 chk("drain_mult_reset", int'(mult_reset[0]), 1);
    chk("drain_acc_enable", int'(acc_enable[0]), 1);
    #1 rstn = 0;
    #1 chk("async_mult_reset", int'(mult_reset[0]), 0);
    chk("async_acc_enable", int'(acc_enable[0]), 0);
    chk("async_in_ready", int'(in_ready[0]), 0);
    chk("async_ch", int'(ch_sel[1]), 0);
    chk("async_mult_enable_d1", int'(mult_enable[1]), 0);
    @(negedge clk);
    #1 rstn = 1;
    start_frame();
    frame_lit();
    repeat (25) @(posedge clk);
    b_acc = acc0;
    @(posedge clk);
    #1 in_valid = 1;
    repeat (12) @(posedge clk);
    #1 in_valid = 0;
    chk("held_valid_accepts", acc0 - b_acc, 2);
    @(negedge clk);
`ifdef IIR_SEQ_OVERRUN_EN
    chk("overrun_set", int'(overrun[0]), 1);
`else
    chk("overrun_off", int'(overrun[0]), 0);
`endif
    repeat (30) @(posedge clk);
    @(negedge clk);
`ifdef IIR_SEQ_OVERRUN_EN
    chk("overrun_sticky", int'(overrun), 7);
`else
    chk("overrun_tied", int'(overrun), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
